// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped instruction cache with block fill sequencer
module icache_controller #(
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             read,
    input  logic [9:0]       pc,
    output logic [31:0]      instruction,
    output logic             busywait,
    output logic             mem_read,
    output logic [5:0]       mem_address,
    input  logic [127:0]     mem_readinst,
    input  logic             mem_busywait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_SETS-1:0] valid;
    logic [2:0]          tag_array  [NUM_SETS];
    logic [127:0]        data_array [NUM_SETS];
    logic                first_cycle;
    logic                filled;

    logic [2:0]          index;
    logic [2:0]          tag;
    logic [127:0]        line;
    logic                hit;
    logic                unused_pc_bits;

    assign index          = pc[6:4];
    assign tag            = pc[9:7];
    assign line           = data_array[index];
    assign unused_pc_bits = ^pc[1:0];

    // Hit detection is purely combinational from the current fetch address.
    always_comb begin
        hit = read & valid[index] & (tag_array[index] == tag);
    end

    // Word select within the 128-bit line; zero unless the fetch hits.
    always_comb begin
        instruction = 32'h0;
        if (hit) begin
            case (pc[3:2])
                2'd0:    instruction = line[31:0];
                2'd1:    instruction = line[63:32];
                2'd2:    instruction = line[95:64];
                default: instruction = line[127:96];
            endcase
        end
    end

    // CPU stall: misses stall in IDLE, the whole fill stalls; held low while in reset.
    always_comb begin
        busywait = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE:    busywait = read & ~hit;
                default: busywait = 1'b1;
            endcase
        end
    end

    // Fill sequencer with registered memory strobes, valid bits and saturating counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            valid       <= '0;
            mem_read    <= 1'b0;
            mem_address <= 6'd0;
            hit_count   <= '0;
            miss_count  <= '0;
            first_cycle <= 1'b0;
            filled      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    filled <= 1'b0;
                    if (read) begin
                        if (hit) begin
                            // The first hit after a fill is the stalled fetch completing, not a new fetch.
                            if (!filled && (hit_count != '1))
                                hit_count <= hit_count + CNT_W'(1);
                        end else begin
                            if (miss_count != '1)
                                miss_count <= miss_count + CNT_W'(1);
                            mem_address <= {tag, index};
                            mem_read    <= 1'b1;
                            first_cycle <= 1'b1;
                            state       <= MEM_READ;
                        end
                    end
                end
                MEM_READ: begin
                    // Memory only raises busywait after seeing the strobe, so ignore it on the first edge.
                    first_cycle <= 1'b0;
                    if (!first_cycle && !mem_busywait) begin
                        mem_read <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid[mem_address[2:0]] <= 1'b1;
                    filled                  <= 1'b1;
                    state                   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays are written only when a fill completes; they are never cleared.
    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            data_array[mem_address[2:0]] <= mem_readinst;
            tag_array[mem_address[2:0]]  <= mem_address[5:3];
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - directed bench for icache_controller with a behavioural block memory
module tb_icache_controller;

    localparam int CNT_W = 4;
    localparam int LAT   = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             read;
    logic [9:0]       pc;
    logic [31:0]      instruction;
    logic             busywait;
    logic             mem_read;
    logic [5:0]       mem_address;
    logic [127:0]     mem_readinst;
    logic             mem_busywait;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int checks = 0;
    int fails  = 0;

    icache_controller #(.NUM_SETS(8), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .read         (read),
        .pc           (pc),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] r;
        case (a)
            6'd0: r = {32'h0001005A, 32'h02060405, 32'h00050023, 32'h00040019};
            6'd1: r = {32'h11111111, 32'h22222222, 32'h33333333, 32'h03010104};
            default: begin
                for (int i = 0; i < 4; i++)
                    r[32*i +: 32] = {16'hC0DE, 6'b0, a, 2'b00, 2'(i)};
            end
        endcase
        return r;
    endfunction

    logic [2:0] mem_cnt;
    always @(posedge clock) begin
        if (!mem_read)         mem_cnt <= 3'd0;
        else if (mem_cnt != 3'(LAT)) mem_cnt <= mem_cnt + 3'd1;
    end
    assign mem_busywait = mem_read && (mem_cnt != 3'(LAT));
    assign mem_readinst = blk(mem_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_fill();
        int n = 0;
        while (busywait !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("fill_done", {31'b0, busywait}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        read    = 1'b1;
        pc      = 10'h000;
        tick();
        tick();
        check("rst_busywait", {31'b0, busywait}, 32'h0);
        check("rst_mem_read", {31'b0, mem_read}, 32'h0);
        check("rst_mem_addr", {26'b0, mem_address}, 32'h0);
        check("rst_hits", {28'b0, hit_count}, 32'h0);
        check("rst_misses", {28'b0, miss_count}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        reset_n = 1'b1;
        #1;

        // cold miss on block 0
        check("t1_busywait", {31'b0, busywait}, 32'h1);
        tick();
        check("t1_mem_read", {31'b0, mem_read}, 32'h1);
        check("t1_mem_addr", {26'b0, mem_address}, 32'h0);
        wait_fill();
        check("t1_instr", instruction, 32'h00040019);
        check("t1_misses", {28'b0, miss_count}, 32'h1);
        tick();
        check("t1_refill_not_hit", {28'b0, hit_count}, 32'h0);

        // repeat fetch of 0x000 then three more words of the same line
        check("t2_instr0", instruction, 32'h00040019);
        tick();
        pc = 10'h004; #1;
        check("t2_busy4", {31'b0, busywait}, 32'h0);
        check("t2_instr4", instruction, 32'h00050023);
        tick();
        pc = 10'h008; #1;
        check("t2_instr8", instruction, 32'h02060405);
        tick();
        pc = 10'h00C; #1;
        check("t2_instrC", instruction, 32'h0001005A);
        check("t2_no_mem_read", {31'b0, mem_read}, 32'h0);
        tick();
        check("t2_hits", {28'b0, hit_count}, 32'h4);

        // miss on index 1
        pc = 10'h010; #1;
        check("t3_busywait", {31'b0, busywait}, 32'h1);
        tick();
        check("t3_mem_addr", {26'b0, mem_address}, 32'h1);
        wait_fill();
        check("t3_instr", instruction, 32'h03010104);
        check("t3_misses", {28'b0, miss_count}, 32'h2);
        tick();

        // conflict: tag 1 evicts block 0, then block 0 misses again
        pc = 10'h080; #1;
        tick();
        check("t4_mem_addr_evict", {26'b0, mem_address}, 32'h8);
        wait_fill();
        check("t4_instr_evict", instruction, 32'hC0DE0080);
        tick();
        pc = 10'h000; #1;
        check("t4_rehit_miss", {31'b0, busywait}, 32'h1);
        tick();
        check("t4_mem_addr", {26'b0, mem_address}, 32'h0);
        check("t4_misses", {28'b0, miss_count}, 32'h4);
        wait_fill();
        check("t4_instr", instruction, 32'h00040019);
        tick();

        // top of the address space: block 63, index 7, last word
        pc = 10'h3FC; #1;
        tick();
        check("wrap_mem_addr", {26'b0, mem_address}, 32'h3F);
        wait_fill();
        check("wrap_instr", instruction, 32'hC0DE03F3);
        tick();

        // reset during MEM_READ
        pc = 10'h020; #1;
        tick();
        tick();
        check("t5_in_fill", {31'b0, mem_read}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t5_mem_read", {31'b0, mem_read}, 32'h0);
        check("t5_busywait", {31'b0, busywait}, 32'h0);
        check("t5_misses", {28'b0, miss_count}, 32'h0);
        tick();
        reset_n = 1'b1;
        pc = 10'h000; #1;
        check("t5_valid_cleared", {31'b0, busywait}, 32'h1);
        tick();
        check("t5_mem_read2", {31'b0, mem_read}, 32'h1);
        check("t5_mem_addr2", {26'b0, mem_address}, 32'h0);
        wait_fill();
        check("t5_instr", instruction, 32'h00040019);
        check("t5_misses2", {28'b0, miss_count}, 32'h1);
        tick();

        // hit counter saturation
        for (int i = 0; i < 20; i++) begin
            pc = 10'(4 * (i % 4)); #1;
            tick();
        end
        check("t6_hit_sat", {28'b0, hit_count}, 32'hF);
        check("t6_no_miss", {28'b0, miss_count}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
